// File: rtl/mem_pkg.sv
// Shared definitions for the MEM pipeline stage: memory op and size codes,
// the MEM-stage FSM state encoding, and a misalignment helper.
package mem_pkg;

  localparam logic [1:0] MEM_OP_NONE  = 2'b00;
  localparam logic [1:0] MEM_OP_LOAD  = 2'b01;
  localparam logic [1:0] MEM_OP_STORE = 2'b10;

  localparam logic [1:0] MEM_SZ_B = 2'b00;
  localparam logic [1:0] MEM_SZ_H = 2'b01;
  localparam logic [1:0] MEM_SZ_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    REQ   = 2'b01,
    WAIT  = 2'b10,
    DRAIN = 2'b11
  } mem_state_e;

  // Half needs an even address, word needs a 4-byte-aligned address.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      MEM_SZ_B: mis = 1'b0;
      MEM_SZ_H: mis = addr_lo[0];
      default:  mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Byte-lane steering for the data-memory bus: byte enables and replicated
// store data on the way out, lane extraction plus sign/zero extension on the
// way back. Purely combinational.
module mem_lsu_align
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  input  logic        load_unsigned,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_result
);

  logic [1:0]  lane_off;
  logic [31:0] shifted;

  // Lane selection; low address bits a size cannot use are ignored.
  always_comb begin
    be       = 4'b1111;
    wdata    = store_data;
    lane_off = 2'b00;
    case (size)
      MEM_SZ_B: begin
        be       = 4'b0001 << addr_lo;
        wdata    = {4{store_data[7:0]}};
        lane_off = addr_lo;
      end
      MEM_SZ_H: begin
        be       = 4'b0011 << {addr_lo[1], 1'b0};
        wdata    = {2{store_data[15:0]}};
        lane_off = {addr_lo[1], 1'b0};
      end
      default: begin
        be       = 4'b1111;
        wdata    = store_data;
        lane_off = 2'b00;
      end
    endcase
  end

  assign shifted = rdata >> {lane_off, 3'b000};

  // Extend the selected lane(s) to a full register value.
  always_comb begin
    load_result = shifted;
    case (size)
      MEM_SZ_B: load_result = load_unsigned ? {24'h0, shifted[7:0]}
                                            : {{24{shifted[7]}}, shifted[7:0]};
      MEM_SZ_H: load_result = load_unsigned ? {16'h0, shifted[15:0]}
                                            : {{16{shifted[15]}}, shifted[15:0]};
      default:  load_result = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: consumes EX/MEM, runs loads/stores over a
// req/gnt/rvalid bus, and drives the MEM/WB register.
// Build option: define MEM_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses instead of silently dropping the offending address bits.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [4:0]        in_regWAddr,
  input  logic [DATA_W-1:0] in_regRData2,
  input  logic [DATA_W-1:0] in_result,
  input  logic [31:0]       in_pc,
  input  logic [1:0]        in_mem_op,
  input  logic [1:0]        in_mem_size,
  input  logic              in_mem_unsigned,
  input  logic              flush,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_regWAddr,
  output logic [DATA_W-1:0] wb_result,
  output logic [31:0]       wb_pc,
  output logic              wb_misalign
);

  mem_state_e state_reg, state_next;

  // Transaction captured at accept time and held for the whole bus handshake.
  logic [DATA_W-1:0] addr_reg;
  logic [1:0]        size_reg;
  logic              uns_reg;
  logic              we_reg;
  logic [DATA_W-1:0] sdata_reg;
  logic [4:0]        rd_reg;
  logic [31:0]       pc_reg;

  logic              wb_valid_reg;
  logic [4:0]        wb_rd_reg;
  logic [DATA_W-1:0] wb_result_reg;
  logic [31:0]       wb_pc_reg;
  logic              wb_misalign_reg;

  logic        accept;
  logic        is_mem;
  logic        trap;
  logic        wb_complete;
  logic [3:0]  lsu_be;
  logic [31:0] lsu_wdata;
  logic [31:0] lsu_load;

  assign accept = (state_reg == IDLE) && in_valid && !flush;
  assign is_mem = (in_mem_op == MEM_OP_LOAD) || (in_mem_op == MEM_OP_STORE);

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = is_mem && is_misaligned(in_mem_size, in_result[1:0]);
`else
  assign trap = 1'b0;
`endif

  // A response retires to WB only if the instruction was not killed meanwhile.
  assign wb_complete = (state_reg == WAIT) && dmem_rvalid && !flush;

  mem_lsu_align u_align (
    .addr_lo       (addr_reg[1:0]),
    .size          (size_reg),
    .store_data    (sdata_reg),
    .rdata         (dmem_rdata),
    .load_unsigned (uns_reg),
    .be            (lsu_be),
    .wdata         (lsu_wdata),
    .load_result   (lsu_load)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic; a grant that coincides with flush still owes a response.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (accept && is_mem && !trap) state_next = REQ;
      REQ: begin
        if (dmem_gnt)   state_next = flush ? DRAIN : WAIT;
        else if (flush) state_next = IDLE;
      end
      WAIT: begin
        if (dmem_rvalid) state_next = IDLE;
        else if (flush)  state_next = DRAIN;
      end
      DRAIN: if (dmem_rvalid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus outputs are driven only while requesting, otherwise parked at zero.
  always_comb begin
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_be    = 4'b0000;
    dmem_wdata = '0;
    if (state_reg == REQ) begin
      dmem_req   = 1'b1;
      dmem_we    = we_reg;
      dmem_addr  = {addr_reg[ADDR_W-1:2], 2'b00};
      dmem_be    = lsu_be;
      dmem_wdata = lsu_wdata;
    end
  end

  assign stall = (state_reg != IDLE);

  // Capture the memory instruction when it enters the stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_reg  <= '0;
      size_reg  <= MEM_SZ_B;
      uns_reg   <= 1'b0;
      we_reg    <= 1'b0;
      sdata_reg <= '0;
      rd_reg    <= 5'd0;
      pc_reg    <= 32'h0;
    end else if (accept && is_mem) begin
      addr_reg  <= in_result;
      size_reg  <= in_mem_size;
      uns_reg   <= in_mem_unsigned;
      we_reg    <= (in_mem_op == MEM_OP_STORE);
      sdata_reg <= in_regRData2;
      rd_reg    <= in_regWAddr;
      pc_reg    <= in_pc;
    end
  end

  // MEM/WB register: pass-through and trap in one cycle, memory ops on rvalid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid_reg    <= 1'b0;
      wb_rd_reg       <= 5'd0;
      wb_result_reg   <= '0;
      wb_pc_reg       <= 32'h0;
      wb_misalign_reg <= 1'b0;
    end else if (accept && (!is_mem || trap)) begin
      wb_valid_reg    <= 1'b1;
      wb_rd_reg       <= trap ? 5'd0 : in_regWAddr;
      wb_result_reg   <= in_result;
      wb_pc_reg       <= in_pc;
      wb_misalign_reg <= trap;
    end else if (wb_complete) begin
      wb_valid_reg    <= 1'b1;
      wb_rd_reg       <= we_reg ? 5'd0 : rd_reg;
      wb_result_reg   <= we_reg ? addr_reg : lsu_load;
      wb_pc_reg       <= pc_reg;
      wb_misalign_reg <= 1'b0;
    end else begin
      wb_valid_reg    <= 1'b0;
      wb_rd_reg       <= 5'd0;
      wb_misalign_reg <= 1'b0;
    end
  end

  assign wb_valid    = wb_valid_reg;
  assign wb_regWAddr = wb_rd_reg;
  assign wb_result   = wb_result_reg;
  assign wb_pc       = wb_pc_reg;
  assign wb_misalign = wb_misalign_reg;

endmodule
